// File: rtl/hazard_ctrl_gen_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_gen_pkg
// Shared definitions for the second-generation hazard/redirect controller:
//   OPC_LOAD  - RV32 load opcode. Upstream decode uses it to produce ex_is_load.
//   state_t   - controller FSM state encoding (IDLE / STALL / FLUSH).
//   clog2_f   - ceiling log2, used to size the stall/flush down-counter.
//   max_f     - integer maximum.
// -----------------------------------------------------------------------------
package hazard_ctrl_gen_pkg;

  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Ceiling log2. The loop stops at bit 30 so that (1 << i) never wraps
  // negative.
  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 30; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max_f(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_ctrl_gen_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Performance counter. It counts up by one on each cycle with inc=1 and
// sticks at all-ones instead of wrapping.
// Ports:
//   clk  in   clock
//   clr  in   synchronous clear (highest priority)
//   inc  in   count enable for this cycle
//   cnt  out  CNT_W-bit count value
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/hazard_ctrl_gen.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_gen
// Hazard/redirect controller for the 5-stage RV32 in-order pipeline.
// Functions:
//   - Stalls IF/ID on load-use hazards for LU_STALL cycles.
//   - Arbitrates EX- and ID-resolved redirects.
//   - Inserts BR_FLUSH EX bubbles after an EX redirect.
//   - Freezes the whole pipe while data memory is busy.
//   - Keeps saturating stall and flush performance counters.
// Ports:
//   clk, rst_n                      clock and synchronous active-low reset
//   id_rs1/id_rs2(+_vld)            ID source registers and read-enables
//   ex_rd, ex_is_load               destination and load flag of the EX instruction
//   id_jmp_vld, id_imm, id_pc       ID-resolved jump and its offset and PC
//   ex_jmp_vld, ex_jmp_addr         EX-resolved redirect and its target
//   mem_busy                        data memory not ready
//   hold_if, freeze                 IF/ID hold, whole-pipe hold
//   jmp_vld_if, jmp_addr_if         PC redirect into IF
//   inst_vld_ex                     EX valid (0 = bubble)
//   perf_stall, perf_flush          saturating event counters
// All outputs are forced to 0 while rst_n is low.
// -----------------------------------------------------------------------------
module hazard_ctrl_gen
  import hazard_ctrl_gen_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int LU_STALL = 1,
  parameter int BR_FLUSH = 2,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_vld,
  input  logic              id_rs2_vld,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_is_load,
  input  logic              id_jmp_vld,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [XLEN-1:0]   id_pc,
  input  logic              ex_jmp_vld,
  input  logic [XLEN-1:0]   ex_jmp_addr,
  input  logic              mem_busy,
  output logic              hold_if,
  output logic              freeze,
  output logic              jmp_vld_if,
  output logic [XLEN-1:0]   jmp_addr_if,
  output logic              inst_vld_ex,
  output logic [CNT_W-1:0]  perf_stall,
  output logic [CNT_W-1:0]  perf_flush
);

  localparam int CW = clog2_f(max_f(LU_STALL, BR_FLUSH)) + 1;
  localparam logic [CW-1:0] LU_LOAD = CW'(LU_STALL - 1);
  localparam logic [CW-1:0] BR_LOAD = CW'(BR_FLUSH - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic            bub_q;
  logic            lu_hit, ex_redir, id_redir, hold_raw, flush_active;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always_comb begin
    lu_hit = ex_is_load && (ex_rd != '0) &&
             ((id_rs1_vld && (id_rs1 == ex_rd)) || (id_rs2_vld && (id_rs2 == ex_rd)));
    ex_redir = ex_jmp_vld && !mem_busy;
    // An EX redirect makes the ID instruction wrong-path, so it overrides any hold.
    hold_raw = !mem_busy && !ex_redir &&
               ((state_reg == ST_STALL) || ((state_reg == ST_IDLE) && lu_hit));
    flush_active = ex_redir || (state_reg == ST_FLUSH);
    // ID jumps seen during a hold will be presented again. ID jumps seen during
    // a flush are wrong-path.
    id_redir = id_jmp_vld && !ex_redir && !mem_busy && !hold_raw &&
               (state_reg != ST_FLUSH);
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt;
    if (mem_busy) begin
      state_next = state_reg;
      cnt_next   = cnt;
    end else if (ex_redir) begin
      if (BR_FLUSH > 1) begin
        state_next = ST_FLUSH;
        cnt_next   = BR_LOAD;
      end else begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (lu_hit && (LU_STALL > 1)) begin
            state_next = ST_STALL;
            cnt_next   = LU_LOAD;
          end
        end
        // STALL and FLUSH both end after the cycle in which cnt reaches 1.
        ST_STALL, ST_FLUSH: begin
          if (cnt <= CNT_ONE) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt - CNT_ONE;
          end
        end
        default: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt       <= '0;
      bub_q     <= 1'b0;
    end else if (!mem_busy) begin
      state_reg <= state_next;
      cnt       <= cnt_next;
      bub_q     <= hold_raw;
    end
  end

  // hold_raw is already 0 while frozen, so only the flush counter needs the
  // freeze qualifier.
  sat_counter #(.CNT_W(CNT_W)) u_perf_stall (
    .clk (clk),
    .clr (!rst_n),
    .inc (hold_raw),
    .cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_perf_flush (
    .clk (clk),
    .clr (!rst_n),
    .inc (flush_active && !mem_busy),
    .cnt (flush_cnt)
  );

  always_comb begin
    freeze      = rst_n && mem_busy;
    hold_if     = rst_n && hold_raw;
    jmp_vld_if  = rst_n && (ex_redir || id_redir);
    inst_vld_ex = rst_n && !(bub_q || flush_active);
    perf_stall  = {CNT_W{rst_n}} & stall_cnt;
    perf_flush  = {CNT_W{rst_n}} & flush_cnt;
    jmp_addr_if = '0;
    if (rst_n) begin
      if (ex_redir)      jmp_addr_if = ex_jmp_addr;
      else if (id_redir) jmp_addr_if = id_pc + id_imm;
    end
  end

endmodule
